// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_stage_pkg;

  // Width of a virtual instruction address.
  localparam int VIRT_ADDR_WIDTH = 32;

  // Byte distance between consecutive sequential fetches.
  localparam logic [VIRT_ADDR_WIDTH-1:0] FETCH_PC_STEP = VIRT_ADDR_WIDTH'(4);

  // Fetch controller states. Encodings are fixed so that they are stable
  // when probed from outside the block.
  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_MISS = 2'd2
  } fetch_state_e;

  // Force an address onto a word boundary; the low two bits are
  // meaningless for 32-bit instructions.
  function automatic logic [VIRT_ADDR_WIDTH-1:0] word_align(
    input logic [VIRT_ADDR_WIDTH-1:0] addr
  );
    return {addr[VIRT_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: valid bit plus instruction word and its PC.
// Latency: one cycle from load to outputs.
// Backpressure: hold freezes everything; flush beats hold and hold beats load.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       hold,
  input  logic                       flush,
  input  logic [31:0]                instr_in,
  input  logic [VIRT_ADDR_WIDTH-1:0] pc_in,
  output logic                       valid,
  output logic [31:0]                instr,
  output logic [VIRT_ADDR_WIDTH-1:0] pc
);

  // Flush only drops the valid bit; the stale payload is harmless because
  // decode ignores it while valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (hold) begin
      valid <= valid;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the iCache lookup, fills IF/ID.
// Latency: PC presented in cycle N shows up on ifid_* after the next posedge on a hit.
// Backpressure: stall_i freezes PC, IF/ID and FSM; a miss inserts bubbles until hit.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_1000,
  parameter int          MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  output logic [31:0]           icache_addr_o,
  input  logic [31:0]           icache_instr_i,
  input  logic                  icache_hit_i,
  output logic                  ifid_valid_o,
  output logic [31:0]           ifid_instr_o,
  output logic [31:0]           ifid_pc_o,
  output logic                  fetch_busy_o,
  output logic [MISS_CNT_W-1:0] miss_cnt_o
);

  localparam logic [VIRT_ADDR_WIDTH-1:0] BOOT_PC = word_align(RESET_PC);

  fetch_state_e                 state, state_nxt;
  logic [VIRT_ADDR_WIDTH-1:0]   pc, pc_nxt;
  logic [MISS_CNT_W-1:0]        miss_cnt;
  logic                         busy;
  logic                         ifid_load;
  logic                         ifid_hold;
  logic                         ifid_flush;
  logic                         miss_inc;

  // State, PC and the registered busy flag advance together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FS_BOOT;
      pc    <= BOOT_PC;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      busy  <= (state_nxt == FS_MISS);
    end
  end

  // Next-state and IF/ID control. Redirect wins over stall, stall wins
  // over the hit/miss outcome. BOOT spends one cycle letting the iCache
  // settle on the reset PC before any lookup is consumed.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ifid_load  = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    miss_inc   = 1'b0;
    case (state)
      FS_BOOT: begin
        state_nxt = FS_RUN;
        ifid_hold = 1'b1;
      end
      FS_RUN, FS_MISS: begin
        if (redirect_i) begin
          // Any outstanding miss is simply abandoned here.
          pc_nxt     = word_align(redirect_pc_i);
          ifid_flush = 1'b1;
          state_nxt  = FS_RUN;
        end else if (stall_i) begin
          ifid_hold = 1'b1;
        end else if (icache_hit_i) begin
          ifid_load = 1'b1;
          pc_nxt    = pc + FETCH_PC_STEP;
          state_nxt = FS_RUN;
        end else begin
          ifid_flush = 1'b1;
          miss_inc   = 1'b1;
          state_nxt  = FS_MISS;
        end
      end
      default: begin
        state_nxt = FS_BOOT;
        pc_nxt    = BOOT_PC;
        ifid_flush = 1'b1;
      end
    endcase
  end

  // Saturating count of unstalled miss cycles; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_cnt <= '0;
    end else if (miss_inc && (miss_cnt != '1)) begin
      miss_cnt <= miss_cnt + MISS_CNT_W'(1);
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load),
    .hold     (ifid_hold),
    .flush    (ifid_flush),
    .instr_in (icache_instr_i),
    .pc_in    (pc),
    .valid    (ifid_valid_o),
    .instr    (ifid_instr_o),
    .pc       (ifid_pc_o)
  );

  assign icache_addr_o = pc;
  assign fetch_busy_o  = busy;
  assign miss_cnt_o    = miss_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus reset/saturation sequences.
// Latency: inputs driven after posedge, outputs compared 1 time unit after the next posedge.
// Backpressure: stall/miss patterns are part of the vector table.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] icache_addr_o;
  logic [31:0] icache_instr_i;
  logic        icache_hit_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic        fetch_busy_o;
  logic [3:0]  miss_cnt_o;

  int checks = 0;
  int passed = 0;

  fetch_stage #(
    .RESET_PC   (32'h0000_1000),
    .MISS_CNT_W (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .icache_addr_o  (icache_addr_o),
    .icache_instr_i (icache_instr_i),
    .icache_hit_i   (icache_hit_i),
    .ifid_valid_o   (ifid_valid_o),
    .ifid_instr_o   (ifid_instr_o),
    .ifid_pc_o      (ifid_pc_o),
    .fetch_busy_o   (fetch_busy_o),
    .miss_cnt_o     (miss_cnt_o)
  );

  // iCache stand-in: every address returns a distinct, predictable word.
  function automatic logic [31:0] ix(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign icache_instr_i = ix(icache_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        stall;
    logic        hit;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        busy;
    logic [3:0]  cnt;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vec [NVEC];

  function automatic vec_t mk(input logic r, input logic [31:0] rp, input logic s,
                              input logic h, input logic [31:0] a, input logic v,
                              input logic [31:0] p, input logic [31:0] i,
                              input logic b, input logic [3:0] c);
    vec_t t;
    t.redirect = r; t.rpc = rp; t.stall = s; t.hit = h;
    t.addr = a; t.valid = v; t.pc = p; t.instr = i; t.busy = b; t.cnt = c;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [31:0] a, input logic v,
                           input logic [31:0] p, input logic [31:0] i,
                           input logic b, input logic [3:0] c);
    check({tag, " addr"},  icache_addr_o, a);
    check({tag, " valid"}, {31'd0, ifid_valid_o}, {31'd0, v});
    check({tag, " pc"},    ifid_pc_o, p);
    check({tag, " instr"}, ifid_instr_o, i);
    check({tag, " busy"},  {31'd0, fetch_busy_o}, {31'd0, b});
    check({tag, " cnt"},   {28'd0, miss_cnt_o}, {28'd0, c});
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          r  rpc           s  h  addr          v  pc            instr            b  cnt
    vec[0]  = mk(0, 32'h0,        0, 1, 32'h1000,     0, 32'h0,        32'h0,           0, 4'd0); // BOOT->RUN
    vec[1]  = mk(0, 32'h0,        0, 1, 32'h1004,     1, 32'h1000,     ix(32'h1000),    0, 4'd0);
    vec[2]  = mk(0, 32'h0,        0, 1, 32'h1008,     1, 32'h1004,     ix(32'h1004),    0, 4'd0);
    vec[3]  = mk(0, 32'h0,        1, 1, 32'h1008,     1, 32'h1004,     ix(32'h1004),    0, 4'd0); // stall
    vec[4]  = mk(0, 32'h0,        1, 0, 32'h1008,     1, 32'h1004,     ix(32'h1004),    0, 4'd0); // stall, no count
    vec[5]  = mk(0, 32'h0,        0, 0, 32'h1008,     0, 32'h1004,     ix(32'h1004),    1, 4'd1); // miss
    vec[6]  = mk(0, 32'h0,        0, 0, 32'h1008,     0, 32'h1004,     ix(32'h1004),    1, 4'd2);
    vec[7]  = mk(0, 32'h0,        0, 0, 32'h1008,     0, 32'h1004,     ix(32'h1004),    1, 4'd3);
    vec[8]  = mk(0, 32'h0,        0, 1, 32'h100C,     1, 32'h1008,     ix(32'h1008),    0, 4'd3); // miss resolves
    vec[9]  = mk(0, 32'h0,        0, 1, 32'h1010,     1, 32'h100C,     ix(32'h100C),    0, 4'd3);
    vec[10] = mk(0, 32'h0,        0, 0, 32'h1010,     0, 32'h100C,     ix(32'h100C),    1, 4'd4);
    vec[11] = mk(1, 32'h2002,     1, 0, 32'h2000,     0, 32'h100C,     ix(32'h100C),    0, 4'd4); // redirect in MISS w/ stall
    vec[12] = mk(0, 32'h0,        0, 1, 32'h2004,     1, 32'h2000,     ix(32'h2000),    0, 4'd4);
    vec[13] = mk(1, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFC, 0, 32'h2000,     ix(32'h2000),    0, 4'd4); // redirect beats hit
    vec[14] = mk(0, 32'h0,        0, 1, 32'h0,        1, 32'hFFFFFFFC, ix(32'hFFFFFFFC),0, 4'd4); // wrap
    vec[15] = mk(0, 32'h0,        0, 1, 32'h4,        1, 32'h0,        ix(32'h0),       0, 4'd4);
    vec[16] = mk(0, 32'h0,        0, 0, 32'h4,        0, 32'h0,        ix(32'h0),       1, 4'd5);
    vec[17] = mk(0, 32'h0,        1, 0, 32'h4,        0, 32'h0,        ix(32'h0),       1, 4'd5); // stall in MISS
    vec[18] = mk(0, 32'h0,        1, 1, 32'h4,        0, 32'h0,        ix(32'h0),       1, 4'd5);
    vec[19] = mk(0, 32'h0,        0, 1, 32'h8,        1, 32'h4,        ix(32'h4),       0, 4'd5);

    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; icache_hit_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("post_reset", 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0);

    for (int i = 0; i < NVEC; i++) begin
      redirect_i    = vec[i].redirect;
      redirect_pc_i = vec[i].rpc;
      stall_i       = vec[i].stall;
      icache_hit_i  = vec[i].hit;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vec[i].addr, vec[i].valid, vec[i].pc,
                vec[i].instr, vec[i].busy, vec[i].cnt);
    end

    // Saturation: 20 more miss cycles starting from a count of 5.
    redirect_i = 1'b0; stall_i = 1'b0; icache_hit_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_all("saturate", 32'h8, 1'b0, 32'h4, ix(32'h4), 1'b1, 4'hF);

    // Asynchronous reset between edges while stalled in MISS.
    stall_i = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all("async_reset", 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    stall_i = 1'b0;
    icache_hit_i = 1'b1;
    @(posedge clk);
    #1;
    check_all("reboot", 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    check_all("refetch", 32'h1004, 1'b1, 32'h1000, ix(32'h1000), 1'b0, 4'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the instruction cache (iCache) and feeds the IF/ID pipeline register. It owns the program counter, drives the iCache lookup address, and stalls on iCache misses. It accepts branch/exception redirects and decode back-pressure, and presents a valid-tagged instruction/PC pair to decode. It also keeps a saturating count of miss-stall cycles for performance monitoring.

## Interface
Parameters:
- RESET_PC, 32'h0000_1000, PC loaded on reset; bits [1:0] must be 0.
- MISS_CNT_W, 16, width of the miss-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- stall_i  in  1  decode not ready; hold PC and IF/ID.
- redirect_i  in  1  taken branch/jump/exception; load redirect_pc_i and flush.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored and forced to 0.
- icache_addr_o  out  32  lookup address to iCache; equals PC register.
- icache_instr_i  in  32  instruction word returned by iCache.
- icache_hit_i  in  1  iCache hit for icache_addr_o.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_instr_o  out  32  fetched instruction.
- ifid_pc_o  out  32  PC of ifid_instr_o.
- fetch_busy_o  out  1  high while the FSM is in MISS.
- miss_cnt_o  out  MISS_CNT_W  saturating miss-cycle count.

## Operation
- FSM states: BOOT, RUN, MISS.
- Reset values:
  - State BOOT; PC = RESET_PC.
  - ifid_valid_o = 0, ifid_instr_o = 0, ifid_pc_o = 0.
  - fetch_busy_o = 0, miss_cnt_o = 0.
- BOOT:
  - No fetch is consumed; IF/ID stays invalid.
  - Unconditionally go to RUN on the next posedge.
  - This gives the iCache one full cycle to settle on RESET_PC.
- Priority in RUN and MISS: redirect_i > stall_i > hit/miss.
- redirect_i=1:
  - PC <= {redirect_pc_i[31:2], 2'b00}; ifid_valid <= 0; state <= RUN.
  - Overrides stall_i.
  - An outstanding miss is abandoned; the iCache refill completes independently and is not tracked.
- stall_i=1 (no redirect):
  - PC, IF/ID contents, ifid_valid and state are all held.
  - miss_cnt is not incremented.
- Hit (no redirect, no stall):
  - ifid_instr <= icache_instr_i; ifid_pc <= PC; ifid_valid <= 1.
  - PC <= PC + 4; state <= RUN.
- Miss (no redirect, no stall, icache_hit_i=0):
  - ifid_valid <= 0 (bubble); PC held; state <= MISS.
  - miss_cnt increments, saturating at all-ones.
- MISS exits to RUN on the first unstalled hit, which is handled as a normal hit.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- fetch_busy_o = (state == MISS). It is a registered output.
- miss_cnt_o is cleared only by reset.

## Timing
- icache_addr_o is driven directly from the PC flop and changes only at posedge or on reset.
- The iCache samples on negedge. icache_instr_i and icache_hit_i must be stable by the following posedge, where fetch_stage samples them (half-cycle path).
- Hit latency: the PC presented in cycle N appears at ifid_* after posedge N+1.
- After reset release:
  - First posedge: BOOT→RUN.
  - Second posedge: first IF/ID update.
- Redirect latency: the target is on icache_addr_o one cycle after redirect_i; its instruction reaches IF/ID one cycle later on a hit.
- Asynchronous reset asserted mid-operation (any state, including MISS with stall_i=1) forces all reset values immediately, without a clock edge.

## Structure
- header.vh holds:
  - `VIRT_ADDR_WIDTH (existing).
  - FSM encodings `FS_BOOT=2'd0, `FS_RUN=2'd1, `FS_MISS=2'd2.
  - `FETCH_PC_STEP=4.
- Sub-module if_id_reg:
  - The IF/ID pipeline register: valid, instr, pc.
  - Controls: load, hold, flush; asynchronous reset.
  - Instantiated once by fetch_stage.
- fetch_stage keeps the PC, FSM and miss counter.

## Test plan
- Reset, RESET_PC=32'h1000, icache_hit_i=1 constant: after BOOT, ifid_pc_o = 0x1000, 0x1004, 0x1008 on consecutive cycles, ifid_valid_o=1 throughout.
- Miss: hit=0 for 3 cycles at PC 0x1008 → icache_addr_o holds 0x1008, ifid_valid_o=0 for 3 cycles, fetch_busy_o=1, miss_cnt_o=3; then hit → ifid_pc_o=0x1008 valid.
- Stall for 2 cycles with IF/ID at 0x1004 → ifid_pc_o/instr unchanged, valid stays 1, PC holds, miss_cnt_o unchanged even if hit=0.
- Redirect in MISS to 32'h2002, with stall_i=1 in the same cycle → next cycle icache_addr_o=0x2000, ifid_valid_o=0, state RUN; then ifid_pc_o=0x2000.
- Wrap: redirect to 0xFFFF_FFFC with hit=1 → next PC 0x0000_0000. Saturation: MISS_CNT_W=4 with 20 miss cycles → miss_cnt_o=4'hF.
- Async reset pulse between clock edges during MISS → all outputs return to reset values immediately and PC=RESET_PC before the next posedge.
